// File: rtl/tpu_arb_pkg.sv
// Shared constants, state type and helpers for the tpu_arb bus arbiter.
// Address legality is only consulted when TPU_ARB_ADDR_CHECK_EN is defined.
package tpu_arb_pkg;

  localparam int unsigned A_BASE     = 32'h0100;
  localparam int unsigned A_LAST     = 32'h0138;
  localparam int unsigned B_BASE     = 32'h0200;
  localparam int unsigned B_LAST     = 32'h0238;
  localparam int unsigned C_BASE     = 32'h0300;
  localparam int unsigned C_LAST     = 32'h0378;
  localparam int unsigned START_ADDR = 32'h0400;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int lock_cycles(input int dim);
    return 3 * dim;
  endfunction

  // Word-aligned A/B/C memory addresses plus the start register.
  function automatic logic addr_legal(input logic [31:0] a);
    logic in_mem;
    in_mem = (a >= A_BASE && a <= A_LAST) ||
             (a >= B_BASE && a <= B_LAST) ||
             (a >= C_BASE && a <= C_LAST);
    return (in_mem && (a[2:0] == 3'b000)) || (a == START_ADDR);
  endfunction

endpackage

// File: rtl/tpu_arb_rr_arb2.sv
// Two-way round-robin grant. prio_reg=0 favours requester 0; the pointer
// moves away from the winner only when upd is asserted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic prio_reg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (upd) begin
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/tpu_arb.sv
// Host/DMA arbiter in front of the tpuv1 port with compute lockout after a start write.
// Optional address filtering is enabled with `define TPU_ARB_ADDR_CHECK_EN.
module tpu_arb
  import tpu_arb_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int DATAW = 64,
  parameter int DIM   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       rw,
  input  logic [ADDRW-1:0] addr0,
  input  logic [ADDRW-1:0] addr1,
  input  logic [DATAW-1:0] wdata0,
  input  logic [DATAW-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       rvalid,
  output logic [DATAW-1:0] rdata,
  output logic [1:0]       err,
  output logic             busy,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_din,
  input  logic [DATAW-1:0] tpu_dout
);

  localparam int CNTW = $clog2(3 * DIM) + 1;
  localparam logic [CNTW-1:0] LOCK_LOAD = CNTW'(lock_cycles(DIM));

  arb_state_t       state_reg, state_next;
  logic [CNTW-1:0]  cnt_reg;
  logic             arb_en;
  logic             win;
  logic             sel_rw;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;
  logic             legal;
  logic             issue;
  logic             start;
  logic             tpu_r_w_reg;
  logic [ADDRW-1:0] tpu_addr_reg;
  logic [DATAW-1:0] tpu_din_reg;
  logic [DATAW-1:0] rdata_reg;
  logic [1:0]       rd_pend;

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .upd (|gnt),
    .gnt (gnt)
  );

  assign win       = gnt[1];
  assign sel_rw    = rw[win];
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

`ifdef TPU_ARB_ADDR_CHECK_EN
  assign legal = addr_legal(32'(sel_addr));
`else
  assign legal = 1'b1;
`endif

  // A rejected access is still accepted on gnt but never reaches the bus.
  assign issue = (|gnt) && legal;
  assign start = issue && sel_rw && (sel_addr == ADDRW'(START_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (start) state_next = ARB_BUSY;
      ARB_BUSY: if (cnt_reg == CNTW'(1)) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    arb_en = 1'b0;
    case (state_reg)
      ARB_IDLE: arb_en = ~rst;
      ARB_BUSY: busy   = 1'b1;
      default:  arb_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= LOCK_LOAD;
    end else if (state_reg == ARB_BUSY) begin
      cnt_reg <= cnt_reg - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tpu_r_w_reg  <= 1'b0;
      tpu_addr_reg <= '0;
      tpu_din_reg  <= '0;
    end else begin
      tpu_r_w_reg  <= issue && sel_rw;
      tpu_addr_reg <= issue ? sel_addr : '0;
      tpu_din_reg  <= issue ? sel_wdata : '0;
    end
  end

  assign tpu_r_w  = tpu_r_w_reg;
  assign tpu_addr = tpu_addr_reg;
  assign tpu_din  = tpu_din_reg;

  // tpu_dout follows tpu_addr combinationally, so it is captured one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (|rd_pend) begin
      rdata_reg <= tpu_dout;
    end
  end

  assign rdata = rdata_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic rd_pend_reg;
      logic rvalid_reg;
      logic err_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_pend_reg <= 1'b0;
          rvalid_reg  <= 1'b0;
          err_reg     <= 1'b0;
        end else begin
          rd_pend_reg <= gnt[gi] && legal && !rw[gi];
          rvalid_reg  <= rd_pend_reg;
          err_reg     <= gnt[gi] && !legal;
        end
      end

      assign rd_pend[gi] = rd_pend_reg;
      assign rvalid[gi]  = rvalid_reg;
      assign err[gi]     = err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tpu_arb.sv
// Directed, table-driven bench for tpu_arb with hand-written lockout/reset sequences.
module tb_tpu_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  rw;
  logic [15:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid, err;
  logic [63:0] rdata;
  logic        busy;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_din;
  logic [63:0] tpu_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in for the TPU memory: read data is a fixed pattern of the address.
  function automatic logic [63:0] dout_of(input logic [15:0] a);
    return {16'hD00D, a, 16'hBEEF, ~a};
  endfunction

  assign tpu_dout = dout_of(tpu_addr);

  tpu_arb #(.ADDRW(16), .DATAW(64), .DIM(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rw       (rw),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy),
    .tpu_r_w  (tpu_r_w),
    .tpu_addr (tpu_addr),
    .tpu_din  (tpu_din),
    .tpu_dout (tpu_dout)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [1:0]  e_gnt;
    logic        e_rw;
    logic [15:0] e_addr;
    logic [63:0] e_din;
    logic [1:0]  e_rv;
    logic [63:0] e_rdata;
    logic [1:0]  e_err;
    logic        e_busy;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(
    input logic [1:0] rq, input logic [1:0] dir, input logic [15:0] a0, input logic [15:0] a1,
    input logic [63:0] w0, input logic [63:0] w1, input logic [1:0] eg, input logic erw,
    input logic [15:0] ea, input logic [63:0] ed, input logic [1:0] erv, input logic [63:0] erd,
    input logic [1:0] ee, input logic eb);
    vec_t v;
    v.req = rq; v.rw = dir; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.e_gnt = eg; v.e_rw = erw; v.e_addr = ea; v.e_din = ed;
    v.e_rv = erv; v.e_rdata = erd; v.e_err = ee; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] dir, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [63:0] w0, input logic [63:0] w1);
    req = rq; rw = dir; addr0 = a0; addr1 = a1; wdata0 = w0; wdata1 = w1;
  endtask

  localparam logic [63:0] WD0 = 64'h0807060504030201;
  localparam logic [63:0] WD1 = 64'h1122334455667788;

  initial begin
    logic [15:0] bad_addr;
    logic [1:0]  bad_err;
    logic [1:0]  bad_rv;

    rst = 1'b1;
    drive(2'b11, 2'b00, 16'h0300, 16'h0308, 64'd0, 64'd0);
    cyc();
    cyc();
    #2;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tpu_r_w", 64'(tpu_r_w), 64'd0);
    chk("reset_tpu_addr", 64'(tpu_addr), 64'd0);
    chk("reset_tpu_din", tpu_din, 64'd0);
    $display("reset: gnt=%b busy=%b tpu_addr=%h", gnt, busy, tpu_addr);
    cyc();
    rst = 1'b0;

`ifdef TPU_ARB_ADDR_CHECK_EN
    bad_addr = 16'h0000; bad_err = 2'b10; bad_rv = 2'b00;
`else
    bad_addr = 16'h0104; bad_err = 2'b00; bad_rv = 2'b10;
`endif

    // Expected outputs are those visible during the vector's own cycle.
    vecs[0]  = mk(2'b11, 2'b00, 16'h0300, 16'h0308, 64'd0, 64'd0, 2'b01, 1'b0, 16'h0000, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[1]  = mk(2'b11, 2'b00, 16'h0300, 16'h0308, 64'd0, 64'd0, 2'b10, 1'b0, 16'h0300, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[2]  = mk(2'b11, 2'b00, 16'h0300, 16'h0308, 64'd0, 64'd0, 2'b01, 1'b0, 16'h0308, 64'd0, 2'b01, dout_of(16'h0300), 2'b00, 1'b0);
    vecs[3]  = mk(2'b11, 2'b00, 16'h0300, 16'h0308, 64'd0, 64'd0, 2'b10, 1'b0, 16'h0300, 64'd0, 2'b10, dout_of(16'h0308), 2'b00, 1'b0);
    vecs[4]  = mk(2'b01, 2'b01, 16'h0100, 16'h0000, WD0,   64'd0, 2'b01, 1'b0, 16'h0308, 64'd0, 2'b01, dout_of(16'h0300), 2'b00, 1'b0);
    vecs[5]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b1, 16'h0100, WD0,   2'b10, dout_of(16'h0308), 2'b00, 1'b0);
    vecs[6]  = mk(2'b10, 2'b00, 16'h0000, 16'h0104, 64'd0, 64'd0, 2'b10, 1'b0, 16'h0000, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[7]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b0, bad_addr, 64'd0, 2'b00, 64'd0, bad_err, 1'b0);
    vecs[8]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b0, 16'h0000, 64'd0, bad_rv, dout_of(16'h0104), 2'b00, 1'b0);
    vecs[9]  = mk(2'b01, 2'b00, 16'h0400, 16'h0000, 64'd0, 64'd0, 2'b01, 1'b0, 16'h0000, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[10] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b0, 16'h0400, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[11] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b0, 16'h0000, 64'd0, 2'b01, dout_of(16'h0400), 2'b00, 1'b0);
    vecs[12] = mk(2'b10, 2'b10, 16'h0000, 16'h0238, 64'd0, WD1,   2'b10, 1'b0, 16'h0000, 64'd0, 2'b00, 64'd0, 2'b00, 1'b0);
    vecs[13] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 64'd0, 64'd0, 2'b00, 1'b1, 16'h0238, WD1,   2'b00, 64'd0, 2'b00, 1'b0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].req, vecs[i].rw, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1);
      #2;
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(vecs[i].e_gnt));
      chk($sformatf("v%0d_tpu_r_w", i), 64'(tpu_r_w), 64'(vecs[i].e_rw));
      chk($sformatf("v%0d_tpu_addr", i), 64'(tpu_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d_tpu_din", i), tpu_din, vecs[i].e_din);
      chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_rv != 2'b00) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      $display("vec %0d: req=%b rw=%b gnt=%b tpu=%b/%h rvalid=%b rdata=%h err=%b",
               i, req, rw, gnt, tpu_r_w, tpu_addr, rvalid, rdata, err);
      cyc();
    end

    // Start write with DMA waiting: 24 busy cycles, DMA granted right after.
    drive(2'b11, 2'b01, 16'h0400, 16'h0200, 64'h0000_0000_0000_0001, 64'd0);
    #2;
    chk("start_gnt", 64'(gnt), 64'd1);
    cyc();
    req = 2'b10;
    for (int k = 1; k <= 24; k++) begin
      #2;
      chk($sformatf("lock%0d_busy", k), 64'(busy), 64'd1);
      chk($sformatf("lock%0d_gnt", k), 64'(gnt), 64'd0);
      if (k == 1) begin
        chk("lock1_tpu_r_w", 64'(tpu_r_w), 64'd1);
        chk("lock1_tpu_addr", 64'(tpu_addr), 64'h0400);
      end
      cyc();
    end
    #2;
    chk("after_lock_busy", 64'(busy), 64'd0);
    chk("after_lock_gnt", 64'(gnt), 64'd2);
    $display("lockout: busy=%b gnt=%b after 24 busy cycles", busy, gnt);
    cyc();
    req = 2'b00;
    #2;
    chk("after_lock_tpu_addr", 64'(tpu_addr), 64'h0200);
    cyc();
    #2;
    chk("after_lock_rvalid", 64'(rvalid), 64'd2);
    chk("after_lock_rdata", rdata, dout_of(16'h0200));
    cyc();

    // Reset on the 10th busy cycle aborts the lockout and restores host priority.
    drive(2'b01, 2'b01, 16'h0400, 16'h0000, 64'd0, 64'd0);
    #2;
    chk("start2_gnt", 64'(gnt), 64'd1);
    cyc();
    drive(2'b11, 2'b00, 16'h0108, 16'h0200, 64'd0, 64'd0);
    for (int k = 1; k <= 9; k++) begin
      #2;
      chk($sformatf("lock2_%0d_busy", k), 64'(busy), 64'd1);
      cyc();
    end
    rst = 1'b1;
    #2;
    chk("lock2_10_busy", 64'(busy), 64'd1);
    cyc();
    rst = 1'b0;
    #2;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_gnt", 64'(gnt), 64'd1);
    $display("abort: busy=%b gnt=%b", busy, gnt);
    cyc();
    req = 2'b00;
    #2;
    chk("abort_tpu_addr", 64'(tpu_addr), 64'h0108);
    cyc();
    #2;
    chk("abort_rvalid", 64'(rvalid), 64'd1);
    chk("abort_rdata", rdata, dout_of(16'h0108));
    cyc();

    // Reset right after a read grant must swallow its rvalid.
    drive(2'b01, 2'b00, 16'h0110, 16'h0000, 64'd0, 64'd0);
    #2;
    chk("drop_gnt", 64'(gnt), 64'd1);
    cyc();
    req = 2'b00;
    rst = 1'b1;
    #2;
    chk("drop_tpu_addr", 64'(tpu_addr), 64'h0110);
    cyc();
    rst = 1'b0;
    #2;
    chk("drop_rvalid", 64'(rvalid), 64'd0);
    chk("drop_tpu_addr_cleared", 64'(tpu_addr), 64'd0);
    $display("drop: rvalid=%b tpu_addr=%h", rvalid, tpu_addr);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
